// File: rtl/lsu_if.sv
// lsu_if -- bundle of the load/store unit's request, memory and response signals.
//
// Modports:
//   slave  : the LSU view. It takes requests, drives the data-memory port and
//            drives the writeback response.
//   master : the environment view (execute stage, data memory, writeback).
//
// Signals:
//   req_valid/req_ready         request handshake (ready only while idle)
//   req_is_store, req_funct3    access kind and RV32I funct3
//   req_addr, req_wdata         effective byte address and rs2 store data
//   mem_valid/mem_ready         memory handshake
//   mem_we, mem_addr            write enable and word-aligned address
//   mem_wmask, mem_wdata        byte enables and lane-replicated store data
//   mem_rdata                   read word, sampled when mem_valid && mem_ready
//   rsp_valid, rsp_rdata        one-cycle response and extended load data
//   rsp_err                     illegal (or trapped misaligned) request
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    output req_ready,
    output mem_valid, mem_we, mem_addr, mem_wmask, mem_wdata,
    input  mem_ready, mem_rdata,
    output rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  mem_valid, mem_we, mem_addr, mem_wmask, mem_wdata,
    output mem_ready, mem_rdata,
    input  rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu.sv
// lsu -- RV32I load/store unit, one outstanding data-memory access at a time.
//
// Ports:
//   clk  core clock, rising edge
//   rst  asynchronous active-high reset (returns to IDLE, drops mem_valid)
//   bus  lsu_if.slave: request in, memory port out, writeback response out
//
// Flow: IDLE accepts a request; legal requests go to MEM and hold registered
// memory outputs until mem_ready, then RESP pulses rsp_valid for one cycle.
// Illegal requests skip MEM and respond with rsp_err in the next cycle.
//
// Configuration macro LSU_MISALIGN_TRAP_EN:
//   defined     misaligned LH/LHU/SH (addr[0]) and LW/SW (addr[1:0]) are errors
//   not defined misaligned halfword/word accesses are forced to natural
//               alignment and proceed
module lsu (
  input  logic  clk,
  input  logic  rst,
  lsu_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;          // byte offset after alignment
  logic        mem_valid_q, mem_valid_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        illegal_s;
  logic        err_s;
  logic [1:0]  off_s;
  logic [3:0]  lane_mask_s;
  logic [31:0] lane_data_s;
  logic [31:0] shifted_s;
  logic [31:0] load_data_s;

  // Decode the incoming request: legality, aligned offset and store lanes.
  always_comb begin
    case (bus.req_funct3)
      3'b011, 3'b110, 3'b111: illegal_s = 1'b1;
      3'b100, 3'b101:         illegal_s = bus.req_is_store;  // no unsigned stores
      default:                illegal_s = 1'b0;
    endcase
    case (bus.req_funct3[1:0])
      2'b00: begin
        off_s       = bus.req_addr[1:0];
        lane_mask_s = 4'b0001 << bus.req_addr[1:0];
        lane_data_s = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        off_s       = {bus.req_addr[1], 1'b0};
        lane_mask_s = 4'b0011 << {bus.req_addr[1], 1'b0};
        lane_data_s = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        off_s       = 2'b00;
        lane_mask_s = 4'b1111;
        lane_data_s = bus.req_wdata;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_s;
  assign misalign_s = ((bus.req_funct3[1:0] == 2'b01) & bus.req_addr[0]) |
                      ((bus.req_funct3[1:0] == 2'b10) & (|bus.req_addr[1:0]));
  assign err_s = illegal_s | misalign_s;
`else
  assign err_s = illegal_s;
`endif

  // Extract and extend the addressed byte/halfword from the returned word.
  always_comb begin
    shifted_s = bus.mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
      3'b100:  load_data_s = {24'd0, shifted_s[7:0]};
      3'b001:  load_data_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
      3'b101:  load_data_s = {16'd0, shifted_s[15:0]};
      default: load_data_s = shifted_s;  // LW: offset is always zero
    endcase
  end

  // Next-state and next-output logic; everything holds unless changed below.
  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wmask_d = mem_wmask_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          is_store_d = bus.req_is_store;
          funct3_d   = bus.req_funct3;
          off_d      = off_s;
          if (err_s) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end else begin
            state_d     = MEM;
            mem_valid_d = 1'b1;
            mem_we_d    = bus.req_is_store;
            mem_addr_d  = {bus.req_addr[31:2], 2'b00};
            mem_wmask_d = bus.req_is_store ? lane_mask_s : 4'b0000;
            mem_wdata_d = bus.req_is_store ? lane_data_s : 32'd0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MEM: begin
        if (bus.mem_ready) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'd0;
          mem_wmask_d = 4'b0000;
          mem_wdata_d = 32'd0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = is_store_q ? 32'd0 : load_data_s;
        end else begin
          state_d = MEM;
        end
      end
      RESP: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;
      end
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wmask_q <= 4'b0000;
      mem_wdata_q <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu -- bench for lsu: directed and randomized transactions, a
// transaction-level reference model and a per-cycle compare process.
module tb_lsu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_if bus ();
  lsu dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;

  // expected outputs for the current cycle, set by the driver after each edge
  logic        chk_en = 1'b0;
  logic        exp_ready, exp_mv, exp_we, exp_rv, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_mask;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what one request must do, from the access rules alone.
  function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rw,
                                output logic err, output logic [31:0] maddr,
                                output logic [3:0] mask, output logic [31:0] mwd,
                                output logic [31:0] rd);
    int nb;
    int off;
    logic [63:0] v;
    nb    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    err   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (st && f3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((int'(a[1:0]) % nb) != 0) err = 1'b1;
`endif
    off   = int'(a[1:0]);
    off   = off - (off % nb);
    maddr = {a[31:2], 2'b00};
    mask  = 4'b0000;
    mwd   = 32'd0;
    rd    = 32'd0;
    if (err) return;
    if (st) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + nb) mask[i] = 1'b1;
        mwd[8*i +: 8] = wd[8*(i % nb) +: 8];
      end
    end else begin
      v = {32'd0, rw} >> (8 * off);
      v = v & ((64'd1 << (8 * nb)) - 64'd1);
      if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | (~64'd0 << (8 * nb));
      rd = v[31:0];
    end
  endfunction

  // Per-cycle comparison of DUT outputs against the expected values.
  always @(negedge clk) begin
    if (chk_en) begin
      check1("req_ready", bus.req_ready, exp_ready);
      check1("mem_valid", bus.mem_valid, exp_mv);
      check1("rsp_valid", bus.rsp_valid, exp_rv);
      if (exp_mv) begin
        check1("mem_we", bus.mem_we, exp_we);
        check32("mem_addr", bus.mem_addr, exp_addr);
        check32("mem_wmask", {28'd0, bus.mem_wmask}, {28'd0, exp_mask});
        if (exp_we) check32("mem_wdata", bus.mem_wdata, exp_wdata);
      end
      if (exp_rv) begin
        check1("rsp_err", bus.rsp_err, exp_err);
        check32("rsp_rdata", bus.rsp_rdata, exp_rdata);
      end
    end
  end

  task automatic scramble_req();
    bus.req_is_store = 1'($urandom_range(0, 1));
    bus.req_funct3   = 3'($urandom_range(0, 7));
    bus.req_addr     = $urandom();
    bus.req_wdata    = $urandom();
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    exp_ready = 1'b1; exp_mv = 1'b0; exp_rv = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One request from accept to response; called at 1 time unit after an edge
  // with the DUT idle. With hold=1, req_valid stays high (fields scrambled).
  task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rw, input int dly,
                     input logic hold);
    logic err;
    logic [31:0] maddr, mwd, rd;
    logic [3:0] mask;
    model(st, f3, a, wd, rw, err, maddr, mask, mwd, rd);
    exp_ready = 1'b1; exp_mv = 1'b0; exp_rv = 1'b0;
    bus.req_valid = 1'b1; bus.req_is_store = st; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = hold;
    if (hold) scramble_req();
    exp_ready = 1'b0;
    if (err) begin
      exp_mv = 1'b0; exp_rv = 1'b1; exp_err = 1'b1; exp_rdata = 32'd0;
      @(posedge clk); #1;
    end else begin
      for (int c = 1; c <= dly; c++) begin
        exp_mv = 1'b1; exp_we = st; exp_addr = maddr; exp_mask = mask; exp_wdata = mwd;
        exp_rv = 1'b0;
        bus.mem_ready = (c == dly);
        bus.mem_rdata = (c == dly) ? rw : $urandom();
        if (hold) scramble_req();
        @(posedge clk); #1;
      end
      bus.mem_ready = 1'b0; bus.mem_rdata = $urandom();
      if (hold) scramble_req();
      exp_mv = 1'b0; exp_rv = 1'b1; exp_err = 1'b0; exp_rdata = rd;
      @(posedge clk); #1;
    end
    exp_rv = 1'b0; exp_ready = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic e;
    logic [31:0] ma, wdx, rdx;
    logic [3:0] mk;

    // model pins: hand-computed values
    model(1'b0, 3'b000, 32'h1003, 32'd0, 32'h80AABBCC, e, ma, mk, wdx, rdx);
    check32("pin_lb_rdata", rdx, 32'hFFFFFF80);
    check32("pin_lb_addr", ma, 32'h0000_1000);
    model(1'b0, 3'b100, 32'h1003, 32'd0, 32'h80AABBCC, e, ma, mk, wdx, rdx);
    check32("pin_lbu_rdata", rdx, 32'h0000_0080);
    model(1'b0, 3'b001, 32'h1002, 32'd0, 32'h80AABBCC, e, ma, mk, wdx, rdx);
    check32("pin_lh_rdata", rdx, 32'hFFFF80AA);
    model(1'b1, 3'b001, 32'h2002, 32'h1234ABCD, 32'd0, e, ma, mk, wdx, rdx);
    check32("pin_sh_mask", {28'd0, mk}, 32'h0000_000C);
    check32("pin_sh_wdata", wdx, 32'hABCDABCD);
    check32("pin_sh_rdata", rdx, 32'd0);
    model(1'b0, 3'b011, 32'h4000, 32'd0, 32'h1, e, ma, mk, wdx, rdx);
    check1("pin_f3_011_err", e, 1'b1);
    model(1'b0, 3'b010, 32'h3001, 32'd0, 32'h5566_7788, e, ma, mk, wdx, rdx);
`ifdef LSU_MISALIGN_TRAP_EN
    check1("pin_lw_mis_err", e, 1'b1);
`else
    check1("pin_lw_mis_err", e, 1'b0);
    check32("pin_lw_mis_addr", ma, 32'h0000_3000);
    check32("pin_lw_mis_rdata", rdx, 32'h5566_7788);
`endif

    // reset state
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_req_ready", bus.req_ready, 1'b1);
    check1("rst_mem_valid", bus.mem_valid, 1'b0);
    check1("rst_mem_we", bus.mem_we, 1'b0);
    check32("rst_mem_addr", bus.mem_addr, 32'd0);
    check32("rst_mem_wmask", {28'd0, bus.mem_wmask}, 32'd0);
    check32("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check32("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check1("rst_rsp_err", bus.rsp_err, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    idle(2);

    // directed cases
    txn(1'b0, 3'b000, 32'h1003, 32'd0, 32'h80AABBCC, 1, 1'b0);
    txn(1'b0, 3'b100, 32'h1003, 32'd0, 32'h80AABBCC, 1, 1'b0);
    txn(1'b1, 3'b001, 32'h2002, 32'h1234ABCD, 32'hDEADBEEF, 3, 1'b0);
    idle(1);
    txn(1'b0, 3'b010, 32'h3001, 32'd0, 32'h5566_7788, 2, 1'b0);
    txn(1'b0, 3'b011, 32'h4000, 32'd0, 32'h1111_2222, 1, 1'b0);
    txn(1'b1, 3'b100, 32'h4004, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);

    // reset while waiting in MEM
    bus.req_valid = 1'b1; bus.req_is_store = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h5000; bus.mem_ready = 1'b0;
    exp_ready = 1'b1; exp_mv = 1'b0; exp_rv = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    exp_ready = 1'b0; exp_mv = 1'b1; exp_we = 1'b0; exp_addr = 32'h5000; exp_mask = 4'b0000;
    @(posedge clk); #1;
    chk_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    check1("midrst_mem_valid", bus.mem_valid, 1'b0);
    check1("midrst_req_ready", bus.req_ready, 1'b1);
    check1("midrst_rsp_valid", bus.rsp_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ready = 1'b1; exp_mv = 1'b0; exp_rv = 1'b0;
    chk_en = 1'b1;
    idle(1);
    txn(1'b0, 3'b001, 32'h6002, 32'd0, 32'h7F00_1234, 2, 1'b0);

    // req_valid held high across three requests
    txn(1'b1, 3'b000, 32'h7001, 32'h0000_00A5, 32'd0, 2, 1'b1);
    txn(1'b0, 3'b101, 32'h7002, 32'd0, 32'h9876_5432, 1, 1'b1);
    txn(1'b0, 3'b010, 32'h7004, 32'd0, 32'hCAFE_F00D, 3, 1'b0);
    idle(2);

    // randomized traffic, including illegal funct3 and misaligned addresses
    for (int t = 0; t < 200; t++) begin
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom(),
          $urandom(), $urandom_range(1, 4), 1'b0);
      idle($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
